// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if : byte-stream input and instruction-memory write port bundle
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;

  // loader side: consumes bytes, drives the memory write port
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, WE, A, WD
  );

  // source / memory side
  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, WE, A, WD
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader : loads a length-prefixed little-endian word stream into imem
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module imem_loader #(
  parameter int          DEPTH_WORDS = 65536,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        start,
  imem_loader_if.master    bus,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      word_count
);

  localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [31:0] n_words;
  logic        rx_ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        xfer;
  logic [31:0] n_full;
  logic [31:0] count_next;

  assign xfer       = bus.rx_valid && rx_ready;
  // length as it will be once the byte arriving now is merged in
  assign n_full     = {bus.rx_data, n_words[23:0]};
  assign count_next = word_count + 32'd1;

  assign bus.rx_ready = rx_ready;
  assign bus.WE       = we;
  assign bus.A        = addr;
  assign bus.WD       = wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      byte_idx   <= 2'd0;
      n_words    <= 32'd0;
      rx_ready   <= 1'b0;
      we         <= 1'b0;
      addr       <= 32'd0;
      wdata      <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= 32'd0;
    end else begin
      we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state      <= S_LEN;
            byte_idx   <= 2'd0;
            n_words    <= 32'd0;
            word_count <= 32'd0;
            done       <= 1'b0;
            error      <= 1'b0;
            rx_ready   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_LEN: begin
          if (xfer) begin
            n_words[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (n_full == 32'd0) begin
                state    <= S_DONE;
                done     <= 1'b1;
                rx_ready <= 1'b0;
                busy     <= 1'b0;
              end else if (n_full > DEPTH) begin
                state    <= S_ERROR;
                error    <= 1'b1;
                rx_ready <= 1'b0;
                busy     <= 1'b0;
              end else begin
                state    <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            wdata[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state    <= S_WRITE;
              rx_ready <= 1'b0;
              we       <= 1'b1;
              addr     <= {BASE_ADDR[31:2], 2'b00} + {word_count[29:0], 2'b00};
            end
          end
        end
        S_WRITE: begin
          word_count <= count_next;
          if (count_next == n_words) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= S_DATA;
            rx_ready <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory: receives a program as a byte stream and drives the memory's write port, one 32-bit word per write.
- Sits between a byte source (UART receiver, test bench) and the instruction memory.
- Holds the core stalled (busy) during a load, so the single-cycle core only fetches once the image is complete.
- Byte order is little-endian, matching the byte-addressed, word-aligned fetch (word index = A[31:2]).

Parameters:
- DEPTH_WORDS, 65536: instruction memory capacity in 32-bit words; larger loads are rejected.
- BASE_ADDR, 32'h00000000: byte address of the first written word; must be a multiple of 4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready.
- WE  output  1  instruction memory write enable, one-cycle pulse per word.
- A  output  32  write byte address, always word-aligned.
- WD  output  32  write data word.
- busy  output  1  load in progress (LEN, DATA or WRITE); core must be held.
- done  output  1  sticky: last load completed successfully.
- error  output  1  sticky: last load rejected (length > DEPTH_WORDS).
- word_count  output  32  words written in the current or last load.

Behaviour:
- Reset values: rx_ready=0, WE=0, A=0, WD=0, busy=0, done=0, error=0, word_count=0; state=IDLE.
- Stream format: 4-byte little-endian word count N, then N words, each 4 bytes little-endian.
- States: IDLE, LEN, DATA, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - go to LEN; clear done, error, word_count, byte index and N.
  - Bytes presented before start are not consumed (rx_ready=0).
- LEN:
  - rx_ready=1; byte k (0..3) goes to N[8k+7:8k].
  - After the 4th accepted byte, next state is decided from the complete N:
    - N==0 -> DONE.
    - N>DEPTH_WORDS -> ERROR.
    - otherwise -> DATA.
- DATA:
  - rx_ready=1; byte k goes to WD[8k+7:8k].
  - After the 4th accepted byte -> WRITE.
- WRITE (exactly one cycle):
  - rx_ready=0; WE=1; A=BASE_ADDR+4*word_count; WD holds the assembled word.
  - word_count increments at the end of the cycle.
  - If the new word_count==N -> DONE, else -> DATA.
- Throughput: minimum 5 cycles per word (4 bytes + 1 write cycle).
- rx_valid gaps (source stalls) are allowed at any point; the byte index advances only on a transfer.
- WE is never asserted outside WRITE. A and WD hold their last values otherwise.
- busy=1 in LEN, DATA and WRITE only.
- done=1 in DONE; error=1 in ERROR. Both hold until start or reset.
- start while busy is ignored: no restart, no state change.
- A start arriving in the same cycle as a byte transfer in DATA is ignored; the transfer proceeds.
- Reset mid-load:
  - Returns to IDLE next edge with all outputs at reset values.
  - Words already written stay in memory; the partial word being assembled is discarded.
- Address arithmetic: 32-bit, wraps modulo 2^32. This cannot occur when BASE_ADDR+4*DEPTH_WORDS ≤ 2^32, which is the legal configuration.
- A byte stream longer than declared is not consumed after DONE (rx_ready=0).

Test Plan:
- Basic load: start; bytes 02 00 00 00, 13 05 A0 00, 93 05 B0 00 -> WE pulses twice:
  - A=0x0, WD=0x00A00513.
  - A=0x4, WD=0x00B00593.
  - Then done=1, busy=0, word_count=2; a read-back through the instruction memory returns the same words.
- Zero length: start; 00 00 00 00 -> DONE with no WE pulse, word_count=0, done=1.
- Oversize with DEPTH_WORDS=4: N=5 -> error=1, no WE; a later start clears error, and N=1 plus word 0xDEADBEEF gives WE at A=0x0, WD=0xDEADBEEF, done=1.
- Source gaps: 1-word load with rx_valid low for 3 cycles between each byte -> exactly one WE, correct WD. Also with BASE_ADDR=0x100: A=0x100.
- Reset mid-load: after 2 of 3 words plus 2 bytes of the third, assert reset -> next cycle all outputs 0, state IDLE. Memory words 0 and 1 are intact; no third write occurs.
- start while busy: pulse start during DATA -> load continues unchanged, word_count keeps counting, completes with done=1.
